// File: rtl/clock_reset_sequencer_pkg.sv
// Shared state encoding, registered-output decode and default timing for the
// 12 MHz board bring-up sequencer.
package clock_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_PERIPH    = 3'd2,
    S_CORE      = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  typedef struct packed {
    logic pll_resetb;
    logic periph_reset_n;
    logic core_reset_n;
    logic ready;
    logic fault;
  } seq_out_t;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_FILTER    = 4;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 4096;
  localparam int unsigned DEF_PERIPH_HOLD    = 64;
  localparam int unsigned DEF_CORE_HOLD      = 128;
  localparam int unsigned DEF_MAX_RETRIES    = 3;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic seq_out_t decode_outputs(input state_e s);
    seq_out_t o;
    o = '0;
    case (s)
      S_WAIT_LOCK, S_PERIPH: o.pll_resetb = 1'b1;
      S_CORE: begin
        o.pll_resetb     = 1'b1;
        o.periph_reset_n = 1'b1;
      end
      S_RUN: begin
        o.pll_resetb     = 1'b1;
        o.periph_reset_n = 1'b1;
        o.core_reset_n   = 1'b1;
        o.ready          = 1'b1;
      end
      S_FAULT: o.fault = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/clock_reset_sequencer_lock_qualifier.sv
// Two-flop synchroniser for the async PLL LOCK plus a consecutive-high filter.
// lock_ok_o is combinational on the registered state: high on the cycle the LOCK_FILTER-th high sample is seen.
module clock_reset_sequencer_lock_qualifier #(
  parameter int unsigned LOCK_FILTER = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lock_async_i,
  input  logic clear_i,
  output logic lock_s_o,
  output logic lock_ok_o
);

  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);

  logic          sync1_q;
  logic          lock_s_q;
  logic [FW-1:0] filt_q;
  logic [FW-1:0] filt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
      filt_q   <= '0;
    end else begin
      sync1_q  <= lock_async_i;
      lock_s_q <= sync1_q;
      filt_q   <= filt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    if (clear_i || !lock_s_q) begin
      filt_d = '0;
    end else if (filt_q != FW'(LOCK_FILTER)) begin
      filt_d = filt_q + FW'(1);
    end
  end

  assign lock_s_o  = lock_s_q;
  assign lock_ok_o = lock_s_q && (filt_q == FW'(LOCK_FILTER - 1));

endmodule

// File: rtl/clock_reset_sequencer.sv
// PLL / peripheral / core reset sequencer on the 12 MHz reference clock.
// All outputs registered from next state; lock decisions lag pll_locked by 2 cycles.
module clock_reset_sequencer
  import clock_reset_sequencer_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_FILTER    = DEF_LOCK_FILTER,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned PERIPH_HOLD    = DEF_PERIPH_HOLD,
  parameter int unsigned CORE_HOLD      = DEF_CORE_HOLD,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       clk_12mhz,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_resetb,
  output logic       periph_reset_n,
  output logic       core_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count
);

  localparam int unsigned CW =
    $clog2(max4(PLL_RST_CYCLES, LOCK_TIMEOUT, PERIPH_HOLD, CORE_HOLD) + 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    retry_q;
  logic [3:0]    retry_d;
  seq_out_t      out_q;
  logic          lock_s;
  logic          lock_ok;

  clock_reset_sequencer_lock_qualifier #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock_qual (
    .clk_i       (clk_12mhz),
    .rst_ni      (reset_n),
    .lock_async_i(pll_locked),
    .clear_i     (state_q != S_WAIT_LOCK),
    .lock_s_o    (lock_s),
    .lock_ok_o   (lock_ok)
  );

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A lock qualifying on the timeout cycle still wins over the retry.
        if (lock_ok) begin
          state_d = S_PERIPH;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
          state_d = (retry_d == 4'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
        end
      end
      S_PERIPH: begin
        if (!lock_s) state_d = S_PLL_RST;
        else if (cnt_q == CW'(PERIPH_HOLD - 1)) state_d = S_CORE;
      end
      S_CORE: begin
        if (!lock_s) state_d = S_PLL_RST;
        else if (cnt_q == CW'(CORE_HOLD - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) state_d = S_PLL_RST;
        else if (soft_reset_req) state_d = S_PERIPH;
      end
      S_FAULT: cnt_d = cnt_q;
      default: state_d = S_PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;
  end

  assign pll_resetb     = out_q.pll_resetb;
  assign periph_reset_n = out_q.periph_reset_n;
  assign core_reset_n   = out_q.core_reset_n;
  assign ready          = out_q.ready;
  assign fault          = out_q.fault;
  assign retry_count    = retry_q;

endmodule
